// File: rtl/instr_word_encoder.sv
// Instruction word encoder: validates and packs immediate or register-register
// field sets into 16-bit words, buffered in a small in-order output queue.
module instr_word_encoder #(
    parameter int WORD_SIZE = 16,
    parameter int DEPTH     = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_imm_mode,
    input  logic [7:0]           in_opcode,
    input  logic [2:0]           in_dest,
    input  logic [2:0]           in_src,
    input  logic [7:0]           in_imm8,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_word,
    output logic                 err_illegal,
    output logic [2:0]           count
);

    localparam int         PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] FULL = 3'(DEPTH);

    logic [WORD_SIZE-1:0] mem [DEPTH];
    logic [PW-1:0]        wr_ptr_reg;
    logic [PW-1:0]        rd_ptr_reg;
    logic [2:0]           count_reg;
    logic                 err_reg;

    logic [4:0]           prefix;
    logic                 legal;
    logic [WORD_SIZE-1:0] enc_word;
    logic                 push;
    logic                 pop;
    logic                 transfer;

    assign prefix = in_opcode[4:0];

    always_comb begin
        legal    = 1'b0;
        enc_word = '0;
        if (in_imm_mode) begin
            legal    = (prefix >= 5'd5) && (prefix <= 5'd17);
            enc_word = {prefix, in_dest, in_imm8};
        end else begin
            legal    = (in_opcode >= 8'h06) && (in_opcode <= 8'h13);
            enc_word = {in_opcode, 1'b0, in_dest, 1'b0, in_src};
        end
    end

    // Occupancy alone decides readiness, so a pop never frees a slot in the same cycle.
    assign in_ready  = (count_reg != FULL);
    assign out_valid = (count_reg != 3'd0);
    assign transfer  = in_valid && in_ready;
    assign push      = transfer && legal;
    assign pop       = out_valid && out_ready;

    assign out_word    = out_valid ? mem[rd_ptr_reg] : '0;
    assign err_illegal = err_reg;
    assign count       = count_reg;

    // Storage is left uncleared by reset; occupancy alone qualifies it.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= enc_word;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= 3'd0;
            err_reg    <= 1'b0;
        end else begin
            err_reg <= transfer && !legal;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_word_encoder.sv
// Self-checking bench for instr_word_encoder: directed cases plus randomized
// traffic compared against a queue-based reference model.
module tb_instr_word_encoder;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_imm_mode;
    logic [7:0]  in_opcode;
    logic [2:0]  in_dest;
    logic [2:0]  in_src;
    logic [7:0]  in_imm8;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic        err_illegal;
    logic [2:0]  count;

    int tests_run    = 0;
    int tests_failed = 0;

    int unsigned model_q[$];
    bit          exp_err;

    instr_word_encoder #(.WORD_SIZE(16), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_imm_mode (in_imm_mode),
        .in_opcode   (in_opcode),
        .in_dest     (in_dest),
        .in_src      (in_src),
        .in_imm8     (in_imm8),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .err_illegal (err_illegal),
        .count       (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit ref_legal(input bit imm, input int unsigned op);
        if (imm) return ((op % 32) >= 5) && ((op % 32) <= 17);
        return (op >= 6) && (op <= 19);
    endfunction

    function automatic int unsigned ref_encode(input bit imm, input int unsigned op,
                                               input int unsigned dest, input int unsigned src,
                                               input int unsigned imm8);
        if (imm) return (op % 32) * 2048 + dest * 256 + imm8;
        return op * 256 + dest * 16 + src;
    endfunction

    task automatic drive(input bit v, input bit imm, input int unsigned op, input int unsigned dest,
                         input int unsigned src, input int unsigned imm8, input bit ordy);
        in_valid    = v;
        in_imm_mode = imm;
        in_opcode   = 8'(op);
        in_dest     = 3'(dest);
        in_src      = 3'(src);
        in_imm8     = 8'(imm8);
        out_ready   = ordy;
    endtask

    task automatic drive_legal_random(input bit ordy);
        bit imm;
        int unsigned op;
        imm = 1'($urandom % 2);
        if (imm) op = ($urandom_range(0, 7) * 32) + $urandom_range(5, 17);
        else     op = $urandom_range(6, 19);
        drive(1'b1, imm, op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255), ordy);
    endtask

    task automatic check_state(input string tag);
        int unsigned head;
        head = (model_q.size() != 0) ? model_q[0] : 0;
        check({tag, ".count"},     32'(count),       32'(model_q.size()));
        check({tag, ".in_ready"},  32'(in_ready),    32'(model_q.size() != DEPTH));
        check({tag, ".out_valid"}, 32'(out_valid),   32'(model_q.size() != 0));
        check({tag, ".out_word"},  32'(out_word),    head);
        check({tag, ".err"},       32'(err_illegal), 32'(exp_err));
    endtask

    // Advance one clock edge, updating the reference model from the driven inputs.
    task automatic cycle(input string tag);
        bit xfer, leg, pop;
        int unsigned w;
        xfer = in_valid && (model_q.size() < DEPTH);
        leg  = ref_legal(in_imm_mode, in_opcode);
        w    = ref_encode(in_imm_mode, in_opcode, in_dest, in_src, in_imm8);
        pop  = (model_q.size() != 0) && out_ready;
        @(posedge clock);
        #1;
        if (pop) void'(model_q.pop_front());
        if (xfer && leg) model_q.push_back(w);
        exp_err = xfer && !leg;
        $display("[TB] %s: in_v=%0b op=%02h cnt=%0d out_v=%0b word=%04h err=%0b",
                 tag, in_valid, in_opcode, count, out_valid, out_word, err_illegal);
        check_state(tag);
    endtask

    initial begin
        reset_n = 1'b0;
        exp_err = 1'b0;
        drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        #2;
        check_state("reset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Immediate example, then a drain cycle
        drive(1'b1, 1'b1, 8'h05, 3, 0, 8'hA5, 1'b1);
        cycle("imm_2ba5");
        check("imm_2ba5.const", 32'(out_word), 32'h2BA5);
        drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        cycle("drain0");

        drive(1'b1, 1'b0, 8'h10, 5, 2, 0, 1'b1);
        cycle("rr_1052");
        check("rr_1052.const", 32'(out_word), 32'h1052);
        drive(1'b1, 1'b0, 8'h06, 1, 7, 0, 1'b1);
        cycle("rr_op06");
        check("rr_op06.hi", 32'(out_word[15:8]), 32'h06);
        drive(1'b1, 1'b1, 8'h11, 0, 0, 8'h3C, 1'b1);
        cycle("imm_p11");
        check("imm_p11.hi", 32'(out_word[15:11]), 32'h11);
        drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        cycle("drain1");

        // Back-to-back illegal field sets
        drive(1'b1, 1'b0, 8'h14, 2, 3, 0, 1'b1);
        cycle("ill_op14");
        drive(1'b1, 1'b1, 8'h04, 2, 0, 8'h11, 1'b1);
        cycle("ill_p04");
        drive(1'b1, 1'b1, 8'h12, 2, 0, 8'h11, 1'b1);
        cycle("ill_p12");
        drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        cycle("ill_end");

        // Fill while stalled, attempt a fifth, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            drive_legal_random(1'b0);
            cycle($sformatf("fill%0d", i));
        end
        drive_legal_random(1'b0);
        cycle("fill_extra");
        check("full.count", 32'(count), 32'd4);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
            cycle($sformatf("pop%0d", i));
        end

        // Hold occupancy at two with simultaneous push/pop
        for (int i = 0; i < 2; i++) begin
            drive_legal_random(1'b0);
            cycle($sformatf("pre%0d", i));
        end
        for (int i = 0; i < 10; i++) begin
            drive_legal_random(1'b1);
            cycle($sformatf("pushpop%0d", i));
            check("pushpop.count", 32'(count), 32'd2);
        end
        drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        cycle("trim");
        drive_legal_random(1'b0);
        cycle("to3");

        // Asynchronous reset between edges with three words queued
        check("pre_rst.count", 32'(count), 32'd3);
        drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
        reset_n = 1'b0;
        #1;
        model_q.delete();
        exp_err = 1'b0;
        check_state("async_rst");
        #1;
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 8'h0A, 6, 1, 0, 1'b0);
        cycle("post_rst");
        check("post_rst.word", 32'(out_word), 32'h0A61);
        drive(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
        cycle("post_rst_pop");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            bit imm;
            imm = 1'($urandom % 2);
            drive(1'($urandom_range(0, 3) != 0), imm,
                  imm ? $urandom_range(0, 255) : $urandom_range(0, 31),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255),
                  1'($urandom_range(0, 2) != 0));
            cycle($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/instr_word_encoder.md
INSTR_WORD_ENCODER -- requirements
Module: instr_word_encoder

Interface
REQ-001 Parameter WORD_SIZE, default 16, instruction word width; only 16 is supported.
REQ-002 Parameter DEPTH, default 4, output queue entries; power of two, at least 2.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  field set on the in_* ports is presented.
REQ-006 in_ready  output  1  encoder can accept a field set this cycle.
REQ-007 in_imm_mode  input  1  1 = immediate format, 0 = register-register format.
REQ-008 in_opcode  input  8  reg-reg mode: full opcode byte; imm mode: bits [4:0] are the opcode prefix and bits [7:5] are ignored.
REQ-009 in_dest  input  3  destination register (x in imm mode, y in reg-reg mode).
REQ-010 in_src  input  3  source register (z); ignored in imm mode.
REQ-011 in_imm8  input  8  immediate value; ignored in reg-reg mode.
REQ-012 out_valid  output  1  out_word holds a valid encoded word.
REQ-013 out_ready  input  1  consumer takes out_word this cycle.
REQ-014 out_word  output  WORD_SIZE  encoded instruction at the queue head.
REQ-015 err_illegal  output  1  one-cycle pulse when an accepted field set was illegal and dropped.
REQ-016 count  output  3  current queue occupancy, 0..DEPTH.

Function
REQ-017 Immediate encoding: out_word = {prefix[4:0], in_dest, in_imm8}.
  - Legal only if prefix is in 5'd5..5'd17.
  - This places upper byte in 0x28..0x8F.
REQ-018 Reg-reg encoding: out_word = {in_opcode, 1'b0, in_dest, 1'b0, in_src}.
  - Legal only if in_opcode is in 0x06..0x13.
REQ-019 Handshake:
  - in_ready = (count != DEPTH), combinational from registered occupancy only.
  - A transfer occurs when in_valid && in_ready.
REQ-020 Legal transfer: the encoded word is written at the write pointer and count increments at that edge.
  - The word is visible on out_word (when it becomes the head) no earlier than the next cycle.
  - No input-to-output combinational path.
REQ-021 Illegal transfer:
  - The field set is consumed (in_ready honoured), nothing is enqueued and count is unchanged.
  - err_illegal = 1 for exactly the following cycle.
REQ-022 Consecutive illegal transfers produce err_illegal high on consecutive cycles, one per illegal transfer.
REQ-023 out_valid = (count != 0); out_word = head entry when out_valid, else 16'h0000.
REQ-024 Pop occurs when out_valid && out_ready; out_ready while empty is ignored.
REQ-025 Simultaneous legal push and pop: count unchanged; both pointers advance.
REQ-026 When full, in_ready = 0 even if a pop occurs that cycle; there is no full-queue bypass.
REQ-027 When empty, a push is not forwarded combinationally; out_valid rises the cycle after the push.
REQ-028 Read and write pointers wrap modulo DEPTH; words are delivered strictly in acceptance order.
REQ-029 in_* values are sampled only on a transfer edge; changes while in_ready = 0 have no effect.

Reset
REQ-030 On reset_n low, immediately and independent of clock:
  - count = 0, pointers = 0;
  - out_valid = 0, out_word = 16'h0000;
  - err_illegal = 0, in_ready = 1.
REQ-031 Reset mid-operation discards all queued words; queue contents need not be cleared.
REQ-032 The first transfer is possible on the first rising edge after reset_n goes high.

Verification
REQ-033 Imm mode, prefix 5'h05, dest 3, imm8 0xA5, out_ready = 1 -> out_word 16'h2BA5 with out_valid the next cycle; err_illegal stays 0.
REQ-034 Reg-reg, opcode 0x10, dest 5, src 2 -> out_word 16'h1052.
  - Boundary check: opcode 0x06 -> 16'h06xx.
  - Boundary check: imm prefix 5'h11 -> 16'h88xx upper bits.
REQ-035 Illegal inputs each give one err_illegal pulse, count unchanged and out_valid stays 0:
  - reg-reg opcode 0x14;
  - imm prefix 5'h04;
  - imm prefix 5'h12.
REQ-036 out_ready = 0, push 4 legal words W0..W3:
  - count = 4, in_ready = 0, and a 5th presentation is not taken;
  - then out_ready = 1 -> W0..W3 popped in order;
  - in_ready returns to 1 the cycle after the first pop.
REQ-037 With count = 2, push and pop in the same cycle -> count stays 2.
  - Run 10 such cycles to exercise pointer wrap; output order must be preserved.
REQ-038 With count = 3, assert reset_n low between edges:
  - out_valid = 0, count = 0, in_ready = 1 immediately;
  - after release, a new word appears alone at the head.
